bsg_test_node_rx_filter: RTL and testbench

Ingress stage sitting directly upstream of the test node client. It accepts raw ring packets from the test-node ring, checks the 4-bit destination ID in the packet header and discards packets addressed to other clients. Matching packets have the header stripped and pass through a 2-entry elastic buffer, which presents the 75-bit payload to the client with a valid/yumi handshake. A compile-time option adds saturating accept and drop counters for bring-up.

---
 rtl/bsg_test_node_pkg.sv | 15 +
 rtl/bsg_test_node_two_fifo.sv | 64 ++++++
 rtl/bsg_test_node_rx_filter.sv | 85 ++++++++
 tb/tb_bsg_test_node_rx_filter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_test_node_pkg.sv
// Shared test-node definitions: field widths, the payload type and the header offset helper
// used by both ingress and egress.
package bsg_test_node_pkg;

   localparam int unsigned test_node_id_width_gp      = 4;
   localparam int unsigned test_node_payload_width_gp = 75;

   typedef logic [test_node_payload_width_gp-1:0] test_node_payload_t;

   // LSB of the destination-ID field, which sits in the top bits of a ring packet.
   function automatic int unsigned test_node_id_lsb(input int unsigned ring_width);
      return ring_width - test_node_id_width_gp;
   endfunction

endpackage

// File: rtl/bsg_test_node_two_fifo.sv
// Generic 2-entry FIFO: valid/ready on the input side, valid/yumi on the output side.
// Entries are reset so data_o never carries X.
module bsg_test_node_two_fifo #(
   parameter int unsigned width_p = 75
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_q [2];
   logic [width_p-1:0] mem_d [2];
   logic               wptr_q, wptr_d;
   logic               rptr_q, rptr_d;
   logic [1:0]         count_q, count_d;
   logic               enq, deq;

   assign ready_o = (count_q != 2'd2);
   assign v_o     = (count_q != 2'd0);
   assign data_o  = mem_q[rptr_q];

   // A yumi against an empty FIFO is masked here so it cannot move any state.
   assign enq = v_i & ready_o;
   assign deq = yumi_i & v_o;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = ~wptr_q;
      end
      if (deq) begin
         rptr_d = ~rptr_q;
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_q   <= '{default: '0};
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bsg_test_node_rx_filter.sv
// Test-node ingress: drops packets for other clients, buffers matching payloads in a 2-entry FIFO.
// Define BSG_TEST_NODE_RX_FILTER_STATS_EN to build saturating accept/drop counters.
module bsg_test_node_rx_filter
   import bsg_test_node_pkg::*;
#(
   parameter int unsigned ring_width_p = 80,
   parameter int unsigned client_id_p  = 0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    en_i,
   input  logic                    v_i,
   input  logic [ring_width_p-1:0] data_i,
   output logic                    ready_o,
   output logic                    v_o,
   output logic [74:0]             data_o,
   input  logic                    yumi_i,
   output logic [15:0]             accept_count_o,
   output logic [15:0]             drop_count_o
);

   localparam int unsigned id_lsb_lp = test_node_id_lsb(ring_width_p);
   localparam logic [test_node_id_width_gp-1:0] id_lp = test_node_id_width_gp'(client_id_p);

   logic               fifo_ready;
   logic               match;
   logic               accept;
   test_node_payload_t payload;
   logic               unused_data;

   assign match   = (data_i[id_lsb_lp +: test_node_id_width_gp] == id_lp);
   assign payload = data_i[test_node_payload_width_gp-1:0];
   // Bits between the payload and the ID field carry nothing for this node.
   assign unused_data = ^data_i;

   // Non-matching packets also wait on a full buffer so ready_o never depends on data_i.
   assign ready_o = en_i & fifo_ready;
   assign accept  = v_i & ready_o;

   bsg_test_node_two_fifo #(
      .width_p(test_node_payload_width_gp)
   ) u_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (accept & match),
      .data_i (payload),
      .ready_o(fifo_ready),
      .v_o    (v_o),
      .data_o (data_o),
      .yumi_i (yumi_i)
   );

`ifdef BSG_TEST_NODE_RX_FILTER_STATS_EN
   logic [15:0] accept_count_q, accept_count_d;
   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      accept_count_d = accept_count_q;
      drop_count_d   = drop_count_q;
      if (accept && match && (accept_count_q != 16'hFFFF)) begin
         accept_count_d = accept_count_q + 16'd1;
      end
      if (accept && !match && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         accept_count_q <= 16'd0;
         drop_count_q   <= 16'd0;
      end else begin
         accept_count_q <= accept_count_d;
         drop_count_q   <= drop_count_d;
      end
   end

   assign accept_count_o = accept_count_q;
   assign drop_count_o   = drop_count_q;
`else
   assign accept_count_o = 16'h0000;
   assign drop_count_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_bsg_test_node_rx_filter.sv
// Self-checking bench for bsg_test_node_rx_filter: directed table, hand sequences and random
// traffic checked against a queue-based model. Honours BSG_TEST_NODE_RX_FILTER_STATS_EN.
module tb_bsg_test_node_rx_filter;

   localparam int unsigned RW = 80;
`ifdef BSG_TEST_NODE_RX_FILTER_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          en_i;
   logic          v_i;
   logic [RW-1:0] data_i;
   logic          ready_o;
   logic          v_o;
   logic [74:0]   data_o;
   logic          yumi_i;
   logic [15:0]   accept_count_o;
   logic [15:0]   drop_count_o;

   bsg_test_node_rx_filter #(
      .ring_width_p(RW),
      .client_id_p (0)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .en_i          (en_i),
      .v_i           (v_i),
      .data_i        (data_i),
      .ready_o       (ready_o),
      .v_o           (v_o),
      .data_o        (data_o),
      .yumi_i        (yumi_i),
      .accept_count_o(accept_count_o),
      .drop_count_o  (drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue, counters as plain integers.
   logic [74:0] mq[$];
   int          acc_cnt = 0;
   int          drp_cnt = 0;

   logic        l_en, l_v, l_yumi, l_ready;
   logic [3:0]  l_id;
   logic [74:0] l_pl;

   typedef struct {
      logic        en;
      logic        v;
      logic [3:0]  id;
      logic [74:0] pl;
      logic        yumi;
      logic        exp_ready;
      logic        exp_v;
      logic [74:0] exp_data;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] pack(input logic [3:0] id, input logic [74:0] pl);
      logic [RW-1:0] r;
      r = '0;
      r[74:0] = pl;
      r[75] = 1'($urandom);
      r[RW-1 -: 4] = id;
      return r;
   endfunction

   // Drive one cycle of inputs, then compare settled outputs to the model.
   task automatic drive_check(input logic en, input logic v, input logic [3:0] id,
                              input logic [74:0] pl, input logic yumi);
      en_i   = en;
      v_i    = v;
      data_i = pack(id, pl);
      yumi_i = yumi;
      l_en = en; l_v = v; l_id = id; l_pl = pl; l_yumi = yumi;
      l_ready = en && (mq.size() < 2);
      #2;
      chk("ready", 80'(ready_o), 80'(l_ready));
      chk("v_o", 80'(v_o), 80'(mq.size() > 0));
      if (mq.size() > 0) chk("data_o", 80'(data_o), 80'(mq[0]));
      chk("accept_cnt", 80'(accept_count_o), StatsEn ? 80'(acc_cnt) : 80'd0);
      chk("drop_cnt", 80'(drop_count_o), StatsEn ? 80'(drp_cnt) : 80'd0);
   endtask

   task automatic advance();
      @(posedge clk_i);
      if (l_yumi && mq.size() > 0) void'(mq.pop_front());
      if (l_en && l_v && l_ready) begin
         if (l_id == 4'd0) begin
            mq.push_back(l_pl);
            if (acc_cnt < 65535) acc_cnt++;
         end else if (drp_cnt < 65535) begin
            drp_cnt++;
         end
      end
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 4'd0, 75'h1234, 1'b0, 1'b1, 1'b0, 75'h0};
      tbl[1]  = '{1'b1, 1'b1, 4'd3, 75'h55,   1'b0, 1'b1, 1'b1, 75'h1234};
      tbl[2]  = '{1'b1, 1'b0, 4'd0, 75'h0,    1'b0, 1'b1, 1'b1, 75'h1234};
      tbl[3]  = '{1'b1, 1'b1, 4'd0, 75'hA0A,  1'b1, 1'b1, 1'b1, 75'h1234};
      tbl[4]  = '{1'b1, 1'b1, 4'd0, 75'hB0B,  1'b0, 1'b1, 1'b1, 75'hA0A};
      tbl[5]  = '{1'b1, 1'b1, 4'd0, 75'hC0C,  1'b0, 1'b0, 1'b1, 75'hA0A};
      tbl[6]  = '{1'b1, 1'b1, 4'd0, 75'hC0C,  1'b1, 1'b0, 1'b1, 75'hA0A};
      tbl[7]  = '{1'b1, 1'b1, 4'd0, 75'hC0C,  1'b0, 1'b1, 1'b1, 75'hB0B};
      tbl[8]  = '{1'b1, 1'b0, 4'd0, 75'h0,    1'b1, 1'b0, 1'b1, 75'hB0B};
      tbl[9]  = '{1'b1, 1'b0, 4'd0, 75'h0,    1'b1, 1'b1, 1'b1, 75'hC0C};
      tbl[10] = '{1'b1, 1'b0, 4'd0, 75'h0,    1'b1, 1'b1, 1'b0, 75'h0};
      tbl[11] = '{1'b1, 1'b0, 4'd0, 75'h0,    1'b0, 1'b1, 1'b0, 75'h0};

      reset_i = 1'b1;
      en_i    = 1'b0;
      v_i     = 1'b0;
      yumi_i  = 1'b0;
      data_i  = '0;
      #3;
      chk("reset_ready_en0", 80'(ready_o), 80'd0);
      en_i = 1'b1;
      #1;
      chk("reset_ready_en1", 80'(ready_o), 80'd1);
      chk("reset_v_o", 80'(v_o), 80'd0);
      chk("reset_data_o", 80'(data_o), 80'd0);
      chk("reset_accept", 80'(accept_count_o), 80'd0);
      chk("reset_drop", 80'(drop_count_o), 80'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Single match, drop, backpressure with ordered drain, stray yumi while empty.
      for (int i = 0; i < 12; i++) begin
         drive_check(tbl[i].en, tbl[i].v, tbl[i].id, tbl[i].pl, tbl[i].yumi);
         chk($sformatf("tbl%0d_ready", i), 80'(ready_o), 80'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_v", i), 80'(v_o), 80'(tbl[i].exp_v));
         if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), 80'(data_o), 80'(tbl[i].exp_data));
         advance();
      end
      if (StatsEn) begin
         chk("tbl_accept_total", 80'(accept_count_o), 80'd4);
         chk("tbl_drop_total", 80'(drop_count_o), 80'd1);
      end

      // Streaming: 20 back-to-back packets, client yumis every valid cycle.
      for (int i = 0; i <= 20; i++) begin
         drive_check(1'b1, i < 20, 4'd0, 75'(100 + i), i > 0);
         chk("stream_ready", 80'(ready_o), 80'd1);
         if (i > 0) begin
            chk("stream_v", 80'(v_o), 80'd1);
            chk("stream_data", 80'(data_o), 80'(100 + i - 1));
         end
         advance();
      end

      // Enable low while holding two entries: drain continues, nothing accepted.
      drive_check(1'b1, 1'b1, 4'd0, 75'h111, 1'b0); advance();
      drive_check(1'b1, 1'b1, 4'd0, 75'h222, 1'b0); advance();
      drive_check(1'b0, 1'b1, 4'd0, 75'h333, 1'b1);
      chk("en0_ready_a", 80'(ready_o), 80'd0);
      chk("en0_data_a", 80'(data_o), 80'h111);
      advance();
      drive_check(1'b0, 1'b1, 4'd0, 75'h333, 1'b1);
      chk("en0_ready_b", 80'(ready_o), 80'd0);
      chk("en0_data_b", 80'(data_o), 80'h222);
      advance();
      drive_check(1'b0, 1'b1, 4'd0, 75'h333, 1'b0);
      chk("en0_empty", 80'(v_o), 80'd0);
      advance();

      // Asynchronous reset with one entry held.
      drive_check(1'b1, 1'b1, 4'd0, 75'h444, 1'b0); advance();
      drive_check(1'b1, 1'b0, 4'd0, 75'h0, 1'b0);
      chk("pre_reset_v", 80'(v_o), 80'd1);
      reset_i = 1'b1;
      #1;
      chk("async_reset_v", 80'(v_o), 80'd0);
      chk("async_reset_data", 80'(data_o), 80'd0);
      chk("async_reset_accept", 80'(accept_count_o), 80'd0);
      chk("async_reset_drop", 80'(drop_count_o), 80'd0);
      chk("async_reset_ready", 80'(ready_o), 80'd1);
      mq.delete();
      acc_cnt = 0;
      drp_cnt = 0;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [3:0] id;
         id = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
         drive_check(($urandom % 8) != 0, ($urandom % 4) != 0, id,
                     {11'($urandom), $urandom, $urandom}, 1'($urandom));
         advance();
      end

`ifdef BSG_TEST_NODE_RX_FILTER_STATS_EN
      // Saturation of the drop counter.
      for (int i = 0; i < 65540; i++) begin
         drive_check(1'b1, 1'b1, 4'd5, 75'h0, 1'b1);
         advance();
      end
      drive_check(1'b1, 1'b0, 4'd0, 75'h0, 1'b0);
      chk("drop_saturated", 80'(drop_count_o), 80'hFFFF);
      advance();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
